// File: rtl/fanin_pkg.sv
// Shared constants and helpers for the 1024->16 fan-in reduction tree.
package fanin_pkg;

    localparam int unsigned DW         = 16;
    localparam int unsigned LANES      = 64;
    localparam int unsigned FANIN      = 4;
    localparam int unsigned NUM_STAGES = 4;

    localparam logic [DW-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DW-1:0] SAT_MIN = 16'h8000;

    // Each 4-input sum level grows the operand by 2 bits, so no level can overflow.
    function automatic int unsigned stage_width(input int unsigned level);
        return DW + 2 * level;
    endfunction

endpackage

// File: rtl/reduce4_stage.sv
// One registered 4-input reduce node: signed sum (W+2 bits) or signed max (sign-extended).
module reduce4_stage
    import fanin_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               halt_i,
    input  logic               in_v_i,
    input  logic               op_max_i,
    input  logic [FANIN*W-1:0] opnd_i,
    output logic               out_v_o,
    output logic               op_max_o,
    output logic [W+1:0]       res_o
);

    logic signed [W+1:0] ext [FANIN];
    logic signed [W+1:0] sum_d;
    logic signed [W+1:0] max_d;
    logic        [W+1:0] res_q;
    logic                v_q;
    logic                op_q;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < FANIN; i++) begin
            ext[i] = $signed(opnd_i[W*i +: W]);
            sum_d  = sum_d + ext[i];
        end
        max_d = ext[0];
        for (int i = 1; i < FANIN; i++) begin
            if (ext[i] > max_d) begin
                max_d = ext[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            v_q   <= 1'b0;
            op_q  <= 1'b0;
            res_q <= '0;
        end else if (!halt_i) begin
            v_q   <= in_v_i;
            op_q  <= op_max_i;
            res_q <= op_max_i ? max_d : sum_d;
        end
    end

    assign out_v_o  = v_q;
    assign op_max_o = op_q;
    assign res_o    = res_q;

endmodule

// File: rtl/fanin_reduce_1024_16.sv
// Pipelined 4-ary reduction of 64 signed lanes to one 16-bit result (sum with
// saturation/wrap, or max); 3 reduce stages plus a registered formatting stage.
module fanin_reduce_1024_16 #(
    parameter int unsigned DW     = 16,
    parameter int unsigned LANES  = 64,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_v,
    input  logic [LANES*DW-1:0] in_data,
    input  logic                op_max,
    input  logic                halt,
    output logic                red_data_v_w,
    output logic [DW-1:0]       red_data_w,
    output logic                red_ovf_w
);

    import fanin_pkg::FANIN;
    import fanin_pkg::SAT_MAX;
    import fanin_pkg::SAT_MIN;
    import fanin_pkg::stage_width;

    localparam int unsigned N1 = LANES / FANIN;
    localparam int unsigned N2 = N1 / FANIN;
    localparam int unsigned W1 = stage_width(1);
    localparam int unsigned W2 = stage_width(2);
    localparam int unsigned W3 = stage_width(3);
    localparam int unsigned HW = W3 - DW + 1;

    if (LANES != 64 || DW != fanin_pkg::DW) begin : g_bad_cfg
        $error("fanin_reduce_1024_16 supports only DW=16, LANES=64");
    end

    logic [N1-1:0][W1-1:0] s1_res;
    logic [N1-1:0]         s1_v;
    logic [N1-1:0]         s1_op;
    logic [N2-1:0][W2-1:0] s2_res;
    logic [N2-1:0]         s2_v;
    logic [N2-1:0]         s2_op;
    logic [W3-1:0]         s3_res;
    logic                  s3_v;
    logic                  s3_op;

    for (genvar j = 0; j < N1; j++) begin : g_s1
        reduce4_stage #(.W(DW)) u_stage (
            .clk_i    (clk),
            .rst_ni   (rst),
            .halt_i   (halt),
            .in_v_i   (data_v),
            .op_max_i (op_max),
            .opnd_i   (in_data[FANIN*DW*j +: FANIN*DW]),
            .out_v_o  (s1_v[j]),
            .op_max_o (s1_op[j]),
            .res_o    (s1_res[j])
        );
    end

    // Tag copies within a stage are identical; AND-reducing keeps every copy in use.
    for (genvar j = 0; j < N2; j++) begin : g_s2
        reduce4_stage #(.W(W1)) u_stage (
            .clk_i    (clk),
            .rst_ni   (rst),
            .halt_i   (halt),
            .in_v_i   (&s1_v),
            .op_max_i (&s1_op),
            .opnd_i   (s1_res[FANIN*j +: FANIN]),
            .out_v_o  (s2_v[j]),
            .op_max_o (s2_op[j]),
            .res_o    (s2_res[j])
        );
    end

    reduce4_stage #(.W(W2)) u_s3 (
        .clk_i    (clk),
        .rst_ni   (rst),
        .halt_i   (halt),
        .in_v_i   (&s2_v),
        .op_max_i (&s2_op),
        .opnd_i   (s2_res),
        .out_v_o  (s3_v),
        .op_max_o (s3_op),
        .res_o    (s3_res)
    );

    logic [HW-1:0] s3_hi;
    logic          in_range;
    logic [DW-1:0] fmt_data;
    logic          fmt_ovf;
    logic          out_v_q;
    logic [DW-1:0] out_data_q;
    logic          out_ovf_q;

    // Value fits in DW signed bits iff all bits from the sign position upward agree.
    always_comb begin
        s3_hi    = s3_res[W3-1:DW-1];
        in_range = (s3_hi == '0) || (s3_hi == '1);
        fmt_data = s3_res[DW-1:0];
        fmt_ovf  = 1'b0;
        if (!s3_op && !in_range) begin
            fmt_ovf = 1'b1;
            if (SAT_EN) begin
                fmt_data = s3_res[W3-1] ? SAT_MIN : SAT_MAX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_v_q    <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else if (!halt) begin
            out_v_q    <= s3_v;
            out_data_q <= fmt_data;
            out_ovf_q  <= fmt_ovf;
        end
    end

    assign red_data_v_w = out_v_q;
    assign red_data_w   = out_data_q;
    assign red_ovf_w    = out_ovf_q;

endmodule

// File: tb/tb_fanin_reduce_1024_16.sv
// Self-checking bench: table vectors plus stream/halt/reset sequences, scoreboard-checked
// against a saturating instance and a wrapping instance driven in parallel.
module tb_fanin_reduce_1024_16;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          data_v  = 1'b0;
    logic          op_max  = 1'b0;
    logic          halt    = 1'b0;
    logic [1023:0] in_data = '0;

    logic          v_sat, ovf_sat, v_wrap, ovf_wrap;
    logic [15:0]   d_sat, d_wrap;

    always #5 clk = ~clk;

    fanin_reduce_1024_16 #(.SAT_EN(1'b1)) u_dut_sat (
        .clk          (clk),
        .rst          (rst),
        .data_v       (data_v),
        .in_data      (in_data),
        .op_max       (op_max),
        .halt         (halt),
        .red_data_v_w (v_sat),
        .red_data_w   (d_sat),
        .red_ovf_w    (ovf_sat)
    );

    fanin_reduce_1024_16 #(.SAT_EN(1'b0)) u_dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .data_v       (data_v),
        .in_data      (in_data),
        .op_max       (op_max),
        .halt         (halt),
        .red_data_v_w (v_wrap),
        .red_data_w   (d_wrap),
        .red_ovf_w    (ovf_wrap)
    );

    typedef struct {
        logic [1023:0] din;
        logic          op;
        logic [15:0]   exp_sat;
        logic [15:0]   exp_wrap;
        logic          exp_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] sat;
        logic [15:0] wrap;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    int   cyc    = 0;
    logic halt_at_edge = 1'b0;
    logic rst_at_edge  = 1'b0;
    logic        snap_v = 1'b0;
    logic [15:0] snap_d = '0;
    logic        snap_o = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        halt_at_edge <= halt;
        rst_at_edge  <= rst;
    end

    // Outputs are new only after an edge with rst=1 and halt=0; halted edges must freeze them.
    always @(negedge clk) begin
        if (rst_at_edge && halt_at_edge) begin
            chk("halt_frozen_valid", 32'(v_sat), 32'(snap_v));
            chk("halt_frozen_data", 32'(d_sat), 32'(snap_d));
            chk("halt_frozen_ovf", 32'(ovf_sat), 32'(snap_o));
        end else if (rst_at_edge && (v_sat === 1'b1 || v_wrap === 1'b1)) begin
            chk("valid_pair", 32'(v_wrap), 32'(v_sat));
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid with data %h, required no output", d_sat);
            end else begin
                mon_e = sb.pop_front();
                n_out++;
                chk("sat_data", 32'(d_sat), 32'(mon_e.sat));
                chk("sat_ovf", 32'(ovf_sat), 32'(mon_e.ovf));
                chk("wrap_data", 32'(d_wrap), 32'(mon_e.wrap));
                chk("wrap_ovf", 32'(ovf_wrap), 32'(mon_e.ovf));
            end
        end
        snap_v <= v_sat;
        snap_d <= d_sat;
        snap_o <= ovf_sat;
    end

    function automatic logic [1023:0] fill(input logic [15:0] v);
        logic [1023:0] r;
        for (int i = 0; i < 64; i++) r[16*i +: 16] = v;
        return r;
    endfunction

    function automatic logic [1023:0] rnd_lanes();
        logic [1023:0] r;
        int            kind;
        kind = int'($urandom_range(0, 2));
        for (int i = 0; i < 64; i++) begin
            if (kind == 0) r[16*i +: 16] = 16'($urandom);
            else if (kind == 1) r[16*i +: 16] = 16'(int'($urandom_range(0, 1023)) - 512);
            else r[16*i +: 16] = 16'(int'($urandom_range(0, 4095)) + 30000);
        end
        return r;
    endfunction

    // Plain integer reference: full-precision sum and max over the 64 lanes.
    function automatic exp_t model(input logic [1023:0] d, input logic op);
        exp_t               e;
        int                 s;
        int                 m;
        logic signed [15:0] l;
        s = 0;
        m = -32768;
        for (int i = 0; i < 64; i++) begin
            l = d[16*i +: 16];
            s = s + int'(l);
            if (int'(l) > m) m = int'(l);
        end
        if (op) begin
            e.sat  = 16'(m);
            e.wrap = 16'(m);
            e.ovf  = 1'b0;
        end else begin
            e.ovf  = (s > 32767) || (s < -32768);
            e.wrap = 16'(s);
            e.sat  = (s > 32767) ? 16'h7FFF : (s < -32768) ? 16'h8000 : 16'(s);
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1023:0] d, input logic op, input exp_t e);
        in_data = d;
        op_max  = op;
        data_v  = 1'b1;
        sb.push_back(e);
        step();
        data_v = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(v_sat), 32'd0);
        chk({tag, "_data"}, 32'(d_sat), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf_sat), 32'd0);
        chk({tag, "_wvalid"}, 32'(v_wrap), 32'd0);
        chk({tag, "_wdata"}, 32'(d_wrap), 32'd0);
        chk({tag, "_wovf"}, 32'(ovf_wrap), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[9];
        logic [1023:0] ramp;
        logic [1023:0] half;
        logic [1023:0] d;
        logic          op;
        int            lat;
        int            c0;
        int            base;

        for (int i = 0; i < 64; i++) begin
            ramp[16*i +: 16] = 16'(i - 32);
            half[16*i +: 16] = (i < 32) ? 16'h7FFF : 16'h8000;
        end
        ramp[16*17 +: 16] = 16'h1234;

        tbl[0] = '{fill(16'h0001), 1'b0, 16'h0040, 16'h0040, 1'b0};
        tbl[1] = '{fill(16'h7FFF), 1'b0, 16'h7FFF, 16'hFFC0, 1'b1};
        tbl[2] = '{fill(16'h8000), 1'b0, 16'h8000, 16'h0000, 1'b1};
        tbl[3] = '{ramp,           1'b1, 16'h1234, 16'h1234, 1'b0};
        tbl[4] = '{fill(16'hFFFF), 1'b1, 16'hFFFF, 16'hFFFF, 1'b0};
        tbl[5] = '{fill(16'hFFFF), 1'b0, 16'hFFC0, 16'hFFC0, 1'b0};
        tbl[6] = '{ramp,           1'b0, 16'h1223, 16'h1223, 1'b0};
        tbl[7] = '{half,           1'b0, 16'hFFE0, 16'hFFE0, 1'b0};
        tbl[8] = '{fill(16'h8000), 1'b1, 16'h8000, 16'h8000, 1'b0};

        // Reset
        rst = 1'b0;
        step();
        step();
        chk_zero("reset");
        rst = 1'b1;
        step();

        // Single pulse: latency and one-cycle valid
        drive(fill(16'h0001), 1'b0, '{16'h0040, 16'h0040, 1'b0});
        lat = 1;
        while (v_sat !== 1'b1 && lat < 12) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'd4);
        step();
        chk("single_pulse_width", 32'(v_sat), 32'd0);
        drain();

        // Table vectors, back to back
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].din, tbl[i].op, '{tbl[i].exp_sat, tbl[i].exp_wrap, tbl[i].exp_ovf});
        end
        drain();

        // Alternating-mode stream, lanes all = k
        base = n_out;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 1) drive(fill(16'(k)), 1'b1, '{16'(k), 16'(k), 1'b0});
            else drive(fill(16'(k)), 1'b0, '{16'(64 * k), 16'(64 * k), 1'b0});
        end
        drain();
        chk("stream_count", 32'(n_out - base), 32'd8);

        // Random items against the reference model
        for (int k = 0; k < 16; k++) begin
            d  = rnd_lanes();
            op = 1'($urandom_range(0, 1));
            drive(d, op, model(d, op));
        end
        drain();

        // Halt for 3 cycles with 3 items in flight; junk offered during halt is ignored
        base = n_out;
        c0   = 0;
        for (int k = 0; k < 3; k++) begin
            d  = rnd_lanes();
            op = (k == 1);
            drive(d, op, model(d, op));
            if (k == 0) c0 = cyc;
        end
        halt    = 1'b1;
        data_v  = 1'b1;
        in_data = rnd_lanes();
        repeat (3) step();
        halt   = 1'b0;
        data_v = 1'b0;
        lat    = 0;
        while (v_sat !== 1'b1 && lat < 12) begin
            step();
            lat++;
        end
        chk("halt_latency", 32'(cyc - c0 + 1), 32'd7);
        drain();
        chk("halt_count", 32'(n_out - base), 32'd3);

        // Reset with halt=1 and 2 items in flight: everything dropped
        base = n_out;
        for (int k = 0; k < 2; k++) begin
            d = fill(16'h0100);
            drive(d, 1'b0, model(d, 1'b0));
        end
        halt = 1'b1;
        rst  = 1'b0;
        sb.delete();
        step();
        chk_zero("midreset");
        rst  = 1'b1;
        halt = 1'b0;
        repeat (10) step();
        chk("no_stale_output", 32'(n_out - base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
